xor_decrypt_receiver: RTL and testbench

//   Far end of the XOR cipher serial link. Captures the framed serial ciphertext (data/start/end)
//   and a serially loaded 32-bit key. Decrypts each bit on the fly by XOR with the key repeated

---
 rtl/xor_decrypt_receiver.sv | 167 ++++++++++++++++
 tb/tb_xor_decrypt_receiver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_decrypt_receiver.sv
// Receive end of the XOR cipher serial link: serial key load, framed ciphertext capture,
// on-the-fly decryption to a serial plaintext stream and a parallel per-frame plaintext word.
module xor_decrypt_receiver #(
    parameter int KEY_SIZE = 32,
    parameter int MSG_SIZE = 512
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iKey_in,
    input  logic                iLoad_key,
    input  logic                iSerial_in,
    input  logic                iSerial_start,
    input  logic                iSerial_end,
    output logic                oPlain_out,
    output logic                oPlain_valid,
    output logic [MSG_SIZE-1:0] oMessage,
    output logic                oMsg_valid,
    output logic                oKey_valid,
    output logic                oFrame_err
);

    localparam int KIW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
    localparam int KCW = $clog2(KEY_SIZE + 1);
    localparam int BCW = $clog2(MSG_SIZE) + 1;
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(MSG_SIZE - 1);
    localparam logic [KIW-1:0] LAST_KIDX = KIW'(KEY_SIZE - 1);
    localparam logic [KCW-1:0] KEY_FULL  = KCW'(KEY_SIZE);
    localparam bit SINGLE = (MSG_SIZE == 1);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [KEY_SIZE-1:0] key_reg;
    logic [KCW-1:0]      key_cnt_reg;
    logic                key_valid_reg;
    logic [KIW-1:0]      key_idx_reg;
    logic [BCW-1:0]      bit_cnt_reg;
    logic [MSG_SIZE-1:0] shift_reg;
    logic [MSG_SIZE-1:0] msg_reg;
    logic                plain_reg;
    logic                plain_valid_reg;
    logic                msg_valid_reg;
    logic                frame_err_reg;

    logic                capture, restart, done, err, leave;
    logic [KIW-1:0]      kidx_cur;
    logic [KIW-1:0]      key_pos;
    logic                plain_bit;
    logic [MSG_SIZE-1:0] shift_next;

    // A restarting bit is always message bit 0, so it takes the first key bit.
    assign kidx_cur   = restart ? '0 : key_idx_reg;
    assign key_pos    = LAST_KIDX - kidx_cur;
    assign plain_bit  = iSerial_in ^ key_reg[key_pos];
    assign shift_next = (shift_reg << 1) | MSG_SIZE'(plain_bit);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture && !SINGLE) state_next = RECV;
            RECV:    if (done || leave)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        restart = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        leave   = 1'b0;
        if (iEn) begin
            case (state_reg)
                IDLE: begin
                    if (iSerial_start) begin
                        if (!key_valid_reg || (iSerial_end && !SINGLE)) begin
                            err = 1'b1;
                        end else begin
                            capture = 1'b1;
                            restart = 1'b1;
                            if (SINGLE) begin
                                done = iSerial_end;
                                err  = !iSerial_end;
                            end
                        end
                    end
                end
                RECV: begin
                    capture = 1'b1;
                    if (iSerial_start) begin
                        restart = 1'b1;
                        err     = 1'b1;
                        leave   = iSerial_end;
                    end else if (iSerial_end) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            done = 1'b1;
                        end else begin
                            err   = 1'b1;
                            leave = 1'b1;
                        end
                    end else if (bit_cnt_reg == LAST_BIT) begin
                        err   = 1'b1;
                        leave = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            key_reg       <= '0;
            key_cnt_reg   <= '0;
            key_valid_reg <= 1'b0;
        end else if (iEn && state_reg == IDLE) begin
            if (!iLoad_key) begin
                key_cnt_reg <= '0;
            end else if (key_cnt_reg != KEY_FULL) begin
                key_reg     <= (key_reg << 1) | KEY_SIZE'(iKey_in);
                key_cnt_reg <= key_cnt_reg + KCW'(1);
                if (key_cnt_reg == '0)                   key_valid_reg <= 1'b0;
                if (key_cnt_reg == KEY_FULL - KCW'(1))   key_valid_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            key_idx_reg     <= '0;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            msg_reg         <= '0;
            plain_reg       <= 1'b0;
            plain_valid_reg <= 1'b0;
            msg_valid_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            // Pulses are refreshed every cycle so an iEn gap always reads as idle.
            plain_valid_reg <= capture;
            msg_valid_reg   <= done;
            frame_err_reg   <= err;
            if (capture) begin
                plain_reg   <= plain_bit;
                shift_reg   <= shift_next;
                key_idx_reg <= (kidx_cur == LAST_KIDX) ? '0 : kidx_cur + KIW'(1);
                bit_cnt_reg <= restart ? BCW'(1) : bit_cnt_reg + BCW'(1);
            end
            if (done || leave) bit_cnt_reg <= '0;
            if (done)          msg_reg     <= shift_next;
        end
    end

    assign oPlain_out   = plain_reg;
    assign oPlain_valid = plain_valid_reg;
    assign oMessage     = msg_reg;
    assign oMsg_valid   = msg_valid_reg;
    assign oKey_valid   = key_valid_reg;
    assign oFrame_err   = frame_err_reg;

endmodule

// File: tb/tb_xor_decrypt_receiver.sv
// Directed bench for xor_decrypt_receiver: a frame-level reference model checked every cycle,
// plus hand-computed expectations per test.
module tb_xor_decrypt_receiver;

    logic         iClk = 1'b0;
    logic         iRst = 1'b0;
    logic         iEn = 1'b0, iKey_in = 1'b0, iLoad_key = 1'b0;
    logic         iSerial_in = 1'b0, iSerial_start = 1'b0, iSerial_end = 1'b0;
    logic         oPlain_out, oPlain_valid, oMsg_valid, oKey_valid, oFrame_err;
    logic [511:0] oMessage;

    xor_decrypt_receiver #(.KEY_SIZE(32), .MSG_SIZE(512)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iKey_in(iKey_in), .iLoad_key(iLoad_key),
        .iSerial_in(iSerial_in), .iSerial_start(iSerial_start), .iSerial_end(iSerial_end),
        .oPlain_out(oPlain_out), .oPlain_valid(oPlain_valid), .oMessage(oMessage),
        .oMsg_valid(oMsg_valid), .oKey_valid(oKey_valid), .oFrame_err(oFrame_err)
    );

    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0]  m_key;
    int           m_kcnt, m_idx;
    bit           m_kv, m_inf;
    logic [511:0] m_buf, m_msg;
    bit           p_pv, p_po, p_mv, p_err, p_kv;
    logic [511:0] p_msg;
    bit           exp_pv, exp_po, exp_mv, exp_err, exp_kv;
    logic [511:0] exp_msg;

    // Observed-event tallies
    int n_pv = 0, n_ones = 0, n_mv = 0, n_err = 0;
    bit plain_log[$];

    logic [511:0] pat;
    logic [511:0] rnd;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("plain_valid", 512'(oPlain_valid), 512'(exp_pv));
        if (exp_pv && oPlain_valid) chk("plain_out", 512'(oPlain_out), 512'(exp_po));
        chk("msg_valid", 512'(oMsg_valid), 512'(exp_mv));
        chk("frame_err", 512'(oFrame_err), 512'(exp_err));
        chk("key_valid", 512'(oKey_valid), 512'(exp_kv));
        chk("message", oMessage, exp_msg);
        if (oPlain_valid) begin
            n_pv++;
            plain_log.push_back(oPlain_out);
            if (oPlain_out) n_ones++;
        end
        if (oMsg_valid) n_mv++;
        if (oFrame_err) n_err++;
    endtask

    task automatic model_reset();
        m_key = '0; m_kcnt = 0; m_kv = 0; m_inf = 0; m_idx = 0; m_buf = '0; m_msg = '0;
        p_pv = 0; p_po = 0; p_mv = 0; p_err = 0; p_kv = 0; p_msg = '0;
        exp_pv = 0; exp_po = 0; exp_mv = 0; exp_err = 0; exp_kv = 0; exp_msg = '0;
    endtask

    // Frame rules: bit i decrypts with key bit 31-(i mod 32); plaintext bit i lands at 511-i.
    task automatic model_step(input bit en, ld, kb, d, st, nd);
        bit was_inf;
        int i;
        was_inf = m_inf;
        p_pv = 0; p_mv = 0; p_err = 0;
        if (en) begin
            i = -1;
            if (!m_inf) begin
                if (st) begin
                    if (!m_kv || nd) p_err = 1;
                    else begin i = 0; m_inf = 1; end
                end
            end else begin
                i = st ? 0 : m_idx;
                if (st) begin
                    p_err = 1;
                    if (nd) m_inf = 0;
                end else if (nd) begin
                    if (i == 511) p_mv = 1;
                    else begin p_err = 1; m_inf = 0; end
                end else if (i == 511) begin
                    p_err = 1; m_inf = 0;
                end
            end
            if (i >= 0) begin
                p_pv = 1;
                p_po = d ^ m_key[31 - (i % 32)];
                m_buf[511 - i] = p_po;
                m_idx = i + 1;
                if (p_mv) begin m_msg = m_buf; m_inf = 0; end
            end
            if (!was_inf) begin
                if (!ld) m_kcnt = 0;
                else if (m_kcnt < 32) begin
                    if (m_kcnt == 0) m_kv = 0;
                    m_key = {m_key[30:0], kb};
                    m_kcnt++;
                    if (m_kcnt == 32) m_kv = 1;
                end
            end
        end
        p_msg = m_msg;
        p_kv  = m_kv;
    endtask

    task automatic step(input bit en, ld, kb, d, st, nd);
        @(posedge iClk); #1;
        exp_pv = p_pv; exp_po = p_po; exp_mv = p_mv; exp_err = p_err;
        exp_msg = p_msg; exp_kv = p_kv;
        iEn = en; iLoad_key = ld; iKey_in = kb; iSerial_in = d;
        iSerial_start = st; iSerial_end = nd;
        model_step(en, ld, kb, d, st, nd);
        @(negedge iClk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(posedge iClk); #1;
        iRst = 1'b0;
        iEn = 0; iLoad_key = 0; iKey_in = 0; iSerial_in = 0; iSerial_start = 0; iSerial_end = 0;
        model_reset();
        @(negedge iClk);
        compare_outputs();
        for (int k = 0; k < 2; k++) begin
            @(posedge iClk); #1;
            @(negedge iClk);
            compare_outputs();
        end
        @(posedge iClk); #1;
        iRst = 1'b1;
    endtask

    task automatic load_key(input logic [31:0] k, input int n);
        bit kb;
        for (int i = 0; i < n; i++) begin
            kb = (i < 32) ? k[31 - i] : 1'($urandom_range(0, 1));
            step(1, 1, kb, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input logic [511:0] c, input int nbits, input int end_at, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            step(1, 0, 0, c[511 - i], i == 0, i == end_at);
        end
        idle(3);
    endtask

    int  b_pv, b_mv, b_err, b_ones, b_log;
    logic [3:0] first4;

    task automatic mark();
        b_pv = n_pv; b_mv = n_mv; b_err = n_err; b_ones = n_ones; b_log = plain_log.size();
    endtask

    initial begin
        pat = {16{32'hDEADBEEF}};
        rnd = {16{$urandom()}};
        model_reset();
        do_reset();
        chk("reset_message", oMessage, 512'd0);
        chk("reset_key_valid", 512'(oKey_valid), 512'd0);
        $display("reset: done");

        // Start with no key, then a truncated key load
        mark();
        step(1, 0, 0, 1, 1, 0);
        idle(2);
        chk("nokey_err_pulses", 512'(n_err - b_err), 512'd1);
        chk("nokey_plain_count", 512'(n_pv - b_pv), 512'd0);
        load_key(32'hDEADBEEF, 20);
        chk("partial_key_valid", 512'(oKey_valid), 512'd0);
        $display("test4: no-key start and 20-bit load");

        load_key(32'hDEADBEEF, 36);
        chk("full_key_valid", 512'(oKey_valid), 512'd1);
        $display("key: loaded DEADBEEF");

        mark();
        send_frame(pat, 512, 511, 0);
        chk("t1_message", oMessage, 512'd0);
        chk("t1_msg_pulses", 512'(n_mv - b_mv), 512'd1);
        chk("t1_plain_count", 512'(n_pv - b_pv), 512'd512);
        chk("t1_plain_ones", 512'(n_ones - b_ones), 512'd0);
        $display("test1: key-pattern frame");

        mark();
        send_frame(512'd0, 512, 511, 0);
        chk("t2_message", oMessage, {16{32'hDEADBEEF}});
        first4 = {plain_log[b_log], plain_log[b_log + 1], plain_log[b_log + 2], plain_log[b_log + 3]};
        chk("t2_first4", 512'(first4), 512'(4'b1101));
        $display("test2: zero frame");

        mark();
        send_frame(rnd, 101, 100, 0);
        chk("t3_err_pulses", 512'(n_err - b_err), 512'd1);
        chk("t3_msg_pulses", 512'(n_mv - b_mv), 512'd0);
        chk("t3_message_kept", oMessage, {16{32'hDEADBEEF}});
        $display("test3: early end");

        mark();
        send_frame(pat, 512, -1, 0);
        chk("noend_err_pulses", 512'(n_err - b_err), 512'd1);
        chk("noend_msg_pulses", 512'(n_mv - b_mv), 512'd0);
        $display("test: frame without end");

        mark();
        send_frame(rnd, 50, -1, 0);
        send_frame(pat, 512, 511, 0);
        chk("restart_err_pulses", 512'(n_err - b_err), 512'd1);
        chk("restart_msg_pulses", 512'(n_mv - b_mv), 512'd1);
        chk("restart_message", oMessage, 512'd0);
        $display("test: start inside frame");

        send_frame(512'd0, 512, 511, 0);
        mark();
        send_frame(pat, 512, 511, 1);
        chk("t5_message", oMessage, 512'd0);
        chk("t5_msg_pulses", 512'(n_mv - b_mv), 512'd1);
        chk("t5_plain_count", 512'(n_pv - b_pv), 512'd512);
        chk("t5_plain_ones", 512'(n_ones - b_ones), 512'd0);
        $display("test5: enable gaps");

        send_frame(pat, 300, -1, 0);
        do_reset();
        chk("t6_message", oMessage, 512'd0);
        chk("t6_key_valid", 512'(oKey_valid), 512'd0);
        load_key(32'hDEADBEEF, 32);
        mark();
        send_frame(512'd0, 512, 511, 0);
        chk("t6_message_after", oMessage, {16{32'hDEADBEEF}});
        chk("t6_msg_pulses", 512'(n_mv - b_mv), 512'd1);
        $display("test6: reset mid-frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
